// File: rtl/dlms_train_ctrl_if.sv
// Control/status bundle between the system register block (master) and the
// DLMS training sequencer (slave).
interface dlms_train_ctrl_if #(
  parameter int W2 = 16,
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic          sample_valid;
  logic [W2-1:0] e_in;
  logic [W2-2:0] thresh;
  logic [7:0]    hold_len;
  logic          clr_coef;
  logic          adapt_en;
  logic          busy;
  logic          converged;
  logic          timeout;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    state;

  // sample_valid is a one-cycle strobe qualifying e_in; there is no ready,
  // the sequencer accepts every strobe in the states that consume samples.
  modport master (
    output start, abort, sample_valid, e_in, thresh, hold_len,
    input  clr_coef, adapt_en, busy, converged, timeout, sample_cnt, state
  );

  modport slave (
    input  start, abort, sample_valid, e_in, thresh, hold_len,
    output clr_coef, adapt_en, busy, converged, timeout, sample_cnt, state
  );
endinterface

// File: rtl/dlms_train_ctrl.sv
// Training sequencer for the pipelined DLMS FIR: clear, pipeline fill, adapt
// until |e| stays in threshold, then freeze. Optional macro DLMS_RETRAIN_EN.
module dlms_train_ctrl #(
  parameter int W2       = 16,
  parameter int PIPE     = 3,
  parameter int MAX_SAMP = 1000,
  parameter int CW       = 16
) (
  input  logic            clk,
  input  logic            reset,
  dlms_train_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FILL   = 3'd2,
    S_TRAIN  = 3'd3,
    S_FROZEN = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] sample_q;
  logic [15:0]   fill_q;
  logic [7:0]    good_q;

  logic [W2-1:0] neg_e;
  logic [W2-2:0] abs_e;
  logic          in_thr;
  logic [7:0]    good_nx;
  logic [7:0]    hold_eff;
  logic [CW-1:0] samp_nx;
  logic [15:0]   fill_nx;

  // Saturating magnitude: the most negative code has no positive twin.
  always_comb begin
    neg_e = ~bus.e_in + {{(W2-1){1'b0}}, 1'b1};
    abs_e = bus.e_in[W2-2:0];
    if (bus.e_in == {1'b1, {(W2-1){1'b0}}})
      abs_e = '1;
    else if (bus.e_in[W2-1])
      abs_e = neg_e[W2-2:0];
  end

  assign in_thr   = (abs_e <= bus.thresh);
  assign good_nx  = in_thr ? ((good_q == 8'hFF) ? good_q : good_q + 8'd1) : 8'd0;
  assign hold_eff = (bus.hold_len == 8'd0) ? 8'd1 : bus.hold_len;
  assign samp_nx  = sample_q + {{(CW-1){1'b0}}, 1'b1};
  assign fill_nx  = fill_q + 16'd1;

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) state_d = S_CLEAR;
        S_CLEAR: state_d = S_FILL;
        S_FILL:  if (bus.sample_valid && (fill_nx >= 16'(PIPE))) state_d = S_TRAIN;
        S_TRAIN: begin
          if (bus.sample_valid) begin
            if (good_nx >= hold_eff)
              state_d = S_FROZEN;
            else if (samp_nx >= CW'(MAX_SAMP))
              state_d = S_FAIL;
          end
        end
        S_FROZEN: begin
          if (bus.start)
            state_d = S_CLEAR;
`ifdef DLMS_RETRAIN_EN
          else if (bus.sample_valid && !in_thr)
            state_d = S_TRAIN;
`endif
        end
        S_FAIL:  if (bus.start) state_d = S_CLEAR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All status outputs are decoded from the next state so they change on the
  // same edge as the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sample_q      <= '0;
      fill_q        <= '0;
      good_q        <= '0;
      bus.clr_coef  <= 1'b0;
      bus.adapt_en  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.converged <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.clr_coef  <= (state_d == S_CLEAR);
      bus.adapt_en  <= (state_d == S_FILL) || (state_d == S_TRAIN);
      bus.busy      <= (state_d == S_CLEAR) || (state_d == S_FILL) || (state_d == S_TRAIN);
      bus.converged <= (state_d == S_FROZEN);
      bus.timeout   <= (state_d == S_FAIL);

      if (state_d == S_CLEAR) begin
        sample_q <= '0;
        fill_q   <= '0;
        good_q   <= '0;
      end else if (!bus.abort && bus.sample_valid) begin
        case (state_q)
          S_FILL: begin
            fill_q   <= fill_nx;
            sample_q <= samp_nx;
          end
          S_TRAIN: begin
            sample_q <= samp_nx;
            good_q   <= good_nx;
          end
`ifdef DLMS_RETRAIN_EN
          S_FROZEN: begin
            if (!in_thr) begin
              sample_q <= '0;
              good_q   <= '0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.sample_cnt = sample_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_dlms_train_ctrl.sv
// Randomised bench for dlms_train_ctrl against a sample-level reference model;
// honours DLMS_RETRAIN_EN when defined.
module tb_dlms_train_ctrl;

  localparam int W2       = 16;
  localparam int PIPE     = 3;
  localparam int MAX_SAMP = 20;
  localparam int CW       = 16;

  localparam int M_IDLE = 0, M_CLEAR = 1, M_FILL = 2, M_TRAIN = 3, M_FROZEN = 4, M_FAIL = 5;

`ifdef DLMS_RETRAIN_EN
  localparam bit RETRAIN = 1'b1;
`else
  localparam bit RETRAIN = 1'b0;
`endif

  logic clk;
  logic reset;

  dlms_train_ctrl_if #(.W2(W2), .CW(CW)) bus ();

  dlms_train_ctrl #(.W2(W2), .PIPE(PIPE), .MAX_SAMP(MAX_SAMP), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_phase = M_IDLE;
  int m_cnt   = 0;
  int m_fill  = 0;
  int m_good  = 0;

  logic [14:0] cur_th = 15'd100;
  logic [7:0]  cur_hl = 8'd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_cnt   = 0;
    m_fill  = 0;
    m_good  = 0;
  endtask

  // One clock of behaviour, written from the training rules at sample level.
  task automatic model_step(input bit st, input bit ab, input bit sv,
                            input int e, input int th, input int hl);
    int mag;
    int need;
    bit ok;
    logic [2:0] ph;
    mag  = (e < 0) ? -e : e;
    if (mag > 32767) mag = 32767;
    ok   = (mag <= th);
    need = (hl == 0) ? 1 : hl;

    if (ab) begin
      m_phase = M_IDLE;
    end else if (m_phase == M_CLEAR) begin
      m_phase = M_FILL;
    end else if (st && (m_phase == M_IDLE || m_phase == M_FROZEN || m_phase == M_FAIL)) begin
      m_phase = M_CLEAR;
      m_cnt = 0; m_fill = 0; m_good = 0;
    end else if (sv && m_phase == M_FILL) begin
      m_fill++;
      m_cnt++;
      if (m_fill >= PIPE) m_phase = M_TRAIN;
    end else if (sv && m_phase == M_TRAIN) begin
      m_cnt++;
      m_good = ok ? ((m_good + 1 > 255) ? 255 : m_good + 1) : 0;
      if (m_good >= need)        m_phase = M_FROZEN;
      else if (m_cnt >= MAX_SAMP) m_phase = M_FAIL;
    end else if (RETRAIN && sv && !ok && m_phase == M_FROZEN) begin
      m_phase = M_TRAIN;
      m_cnt = 0; m_good = 0;
    end

    ph = 3'(m_phase);
    exp_q.push_back({ph,
                     1'(m_phase == M_CLEAR),
                     1'(m_phase == M_FILL || m_phase == M_TRAIN),
                     1'(m_phase >= M_CLEAR && m_phase <= M_TRAIN),
                     1'(m_phase == M_FROZEN),
                     1'(m_phase == M_FAIL),
                     16'(m_cnt)});
  endtask

  task automatic compare_outputs();
    logic [23:0] x;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      check("state",      32'(bus.state),      32'(x[23:21]));
      check("clr_coef",   32'(bus.clr_coef),   32'(x[20]));
      check("adapt_en",   32'(bus.adapt_en),   32'(x[19]));
      check("busy",       32'(bus.busy),       32'(x[18]));
      check("converged",  32'(bus.converged),  32'(x[17]));
      check("timeout",    32'(bus.timeout),    32'(x[16]));
      check("sample_cnt", 32'(bus.sample_cnt), 32'(x[15:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit st, input bit ab, input bit sv, input logic [15:0] e);
    int es;
    @(negedge clk);
    bus.start        = st;
    bus.abort        = ab;
    bus.sample_valid = sv;
    bus.e_in         = e;
    bus.thresh       = cur_th;
    bus.hold_len     = cur_hl;
    es = 32'($signed(e));
    model_step(st, ab, sv, es, int'(cur_th), int'(cur_hl));
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic sample(input logic [15:0] e);
    idle($urandom_range(0, 2));
    step(1'b0, 1'b0, 1'b1, e);
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_abort();
    step(1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic fill_phase();
    for (int i = 0; i < PIPE; i++) sample(16'($urandom_range(0, 65535)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.e_in         = '0;
    bus.thresh       = cur_th;
    bus.hold_len     = cur_hl;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",    32'(bus.state),      32'd0);
    check("rst_adapt",    32'(bus.adapt_en),   32'd0);
    check("rst_cnt",      32'(bus.sample_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Convergence: 3 fill, 5 large, 4 small errors.
    cur_th = 15'd100; cur_hl = 8'd4;
    do_start();
    check("clr_pulse", 32'(bus.clr_coef), 32'd1);
    fill_phase();
    check("in_train", 32'(bus.state), 32'd3);
    for (int i = 0; i < 5; i++) sample(16'd500);
    for (int i = 0; i < 4; i++) sample(16'd50);
    check("conv12_converged", 32'(bus.converged),  32'd1);
    check("conv12_adapt",     32'(bus.adapt_en),   32'd0);
    check("conv12_cnt",       32'(bus.sample_cnt), 32'd12);
    idle(3);

    // Timeout with constant large error, then restart.
    do_start();
    fill_phase();
    for (int i = 0; i < MAX_SAMP - PIPE; i++) sample(16'd1000);
    check("fail_timeout", 32'(bus.timeout),    32'd1);
    check("fail_cnt",     32'(bus.sample_cnt), 32'd20);
    do_start();
    check("restart_state", 32'(bus.state),      32'd1);
    check("restart_cnt",   32'(bus.sample_cnt), 32'd0);

    // Alternating error never holds for 2 samples.
    cur_hl = 8'd2;
    fill_phase();
    for (int i = 0; i < MAX_SAMP - PIPE; i++) sample((i % 2 == 0) ? 16'd50 : 16'd500);
    check("alt_fail", 32'(bus.state), 32'd5);

    // hold_len=0 behaves as 1.
    cur_hl = 8'd0;
    do_start();
    fill_phase();
    sample(16'd50);
    check("hold0_conv", 32'(bus.state),      32'd4);
    check("hold0_cnt",  32'(bus.sample_cnt), 32'd4);

    // Most negative error saturates to 32767.
    cur_th = 15'd32767; cur_hl = 8'd1;
    do_start();
    fill_phase();
    sample(16'h8000);
    check("neg_sat_conv", 32'(bus.converged), 32'd1);

    // Retrain (or not) from FROZEN on a large error.
    cur_th = 15'd100;
    sample(16'd300);
    check("retrain_state", 32'(bus.state),    RETRAIN ? 32'd3 : 32'd4);
    check("retrain_clr",   32'(bus.clr_coef), 32'd0);

    // Abort priority over start; abort during FILL.
    do_abort();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("start_abort_idle", 32'(bus.state), 32'd0);
    do_start();
    sample(16'd10);
    do_abort();
    check("abort_fill_state", 32'(bus.state),    32'd0);
    check("abort_fill_adapt", 32'(bus.adapt_en), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        cur_th = 15'($urandom_range(0, 150));
        cur_hl = 8'($urandom_range(0, 4));
      end
      step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 240) - 120) : 16'($urandom_range(0, 65535)));
    end

    // Asynchronous reset mid-TRAIN at sample 10.
    do_abort();
    cur_th = 15'd100; cur_hl = 8'd4;
    do_start();
    fill_phase();
    for (int i = 0; i < 7; i++) sample(16'd1000);
    check("pre_rst_cnt", 32'(bus.sample_cnt), 32'd10);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(bus.state),      32'd0);
    check("arst_adapt", 32'(bus.adapt_en),   32'd0);
    check("arst_busy",  32'(bus.busy),       32'd0);
    check("arst_clr",   32'(bus.clr_coef),   32'd0);
    check("arst_cnt",   32'(bus.sample_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(2);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
